// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: memory_io request/response
// structs, idle constants, arbiter FSM states and requester identifiers.
package mem_port_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } memory_io_req32;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } memory_io_rsp32;

  localparam memory_io_req32 memory_io_no_req = '{valid: 1'b0, we: 1'b0, be: 4'h0,
                                                  addr: 32'h0, wdata: 32'h0};
  localparam memory_io_rsp32 memory_io_no_rsp = '{valid: 1'b0, data: 32'h0};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} arb_state_t;

  typedef enum logic {REQ_INST, REQ_DATA} req_id_t;

  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter_req_capture_slot.sv
// One-entry request holding register: latches a request when empty, empties on
// grant, and flags requests that arrive while full or while the port is busy.
module req_capture_slot
  import mem_port_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  memory_io_req32 req_in,
  input  logic           blocked,
  input  logic           take,
  output logic           full,
  output memory_io_req32 req_q,
  output logic           drop
);

  logic capture;

  assign capture = req_in.valid && !full && !blocked;
  assign drop    = req_in.valid && (full || blocked);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full  <= 1'b0;
      req_q <= memory_io_no_req;
    end else if (capture) begin
      full  <= 1'b1;
      req_q <= req_in;
    end else if (take) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between instruction fetch
// and data requesters, with one outstanding transaction and a response watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_DATA   = DEFAULT_TIMEOUT_DATA
) (
  input  logic           clk,
  input  logic           reset,
  input  memory_io_req32 inst_req_in,
  output memory_io_rsp32 inst_rsp_out,
  input  memory_io_req32 data_req_in,
  output memory_io_rsp32 data_rsp_out,
  output memory_io_req32 mem_req,
  input  memory_io_rsp32 mem_rsp,
  output logic           inst_busy,
  output logic           data_busy,
  output logic           timeout_err,
  output logic           protocol_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t     state, state_next;
  req_id_t        grant_id, grant_next, last_grant;
  logic           do_grant, rsp_hit, wd_expire;
  logic [CNT_W-1:0] wd_cnt;
  logic [31:0]    rsp_data;
  memory_io_req32 granted_req;

  logic           inst_full, data_full, inst_drop, data_drop;
  logic           inst_take, data_take, inst_blocked, data_blocked;
  logic           inst_outstanding, data_outstanding;
  memory_io_req32 inst_slot_q, data_slot_q;

  // A port is outstanding from grant until the end of its RESPOND cycle, but a
  // fresh capture is allowed to overlap RESPOND.
  assign inst_outstanding = (state != IDLE) && (grant_id == REQ_INST);
  assign data_outstanding = (state != IDLE) && (grant_id == REQ_DATA);
  assign inst_blocked     = (state == ISSUE || state == WAIT) && (grant_id == REQ_INST);
  assign data_blocked     = (state == ISSUE || state == WAIT) && (grant_id == REQ_DATA);
  assign inst_busy        = inst_full || inst_outstanding;
  assign data_busy        = data_full || data_outstanding;

  req_capture_slot u_inst_slot (
    .clk     (clk),
    .reset   (reset),
    .req_in  (inst_req_in),
    .blocked (inst_blocked),
    .take    (inst_take),
    .full    (inst_full),
    .req_q   (inst_slot_q),
    .drop    (inst_drop)
  );

  req_capture_slot u_data_slot (
    .clk     (clk),
    .reset   (reset),
    .req_in  (data_req_in),
    .blocked (data_blocked),
    .take    (data_take),
    .full    (data_full),
    .req_q   (data_slot_q),
    .drop    (data_drop)
  );

  always_comb begin
    state_next  = state;
    grant_next  = grant_id;
    do_grant    = 1'b0;
    rsp_hit     = 1'b0;
    wd_expire   = 1'b0;
    inst_take   = 1'b0;
    data_take   = 1'b0;
    granted_req = memory_io_no_req;
    case (state)
      IDLE: begin
        if (inst_full && data_full) begin
          do_grant   = 1'b1;
          grant_next = (last_grant == REQ_INST) ? REQ_DATA : REQ_INST;
        end else if (inst_full) begin
          do_grant   = 1'b1;
          grant_next = REQ_INST;
        end else if (data_full) begin
          do_grant   = 1'b1;
          grant_next = REQ_DATA;
        end
        if (do_grant) begin
          state_next  = ISSUE;
          inst_take   = (grant_next == REQ_INST);
          data_take   = (grant_next == REQ_DATA);
          granted_req = (grant_next == REQ_INST) ? inst_slot_q : data_slot_q;
          granted_req.valid = 1'b1;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (mem_rsp.valid) begin
          rsp_hit    = 1'b1;
          state_next = RESPOND;
        end else if ((wd_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES)) begin
          wd_expire  = 1'b1;
          state_next = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    inst_rsp_out = memory_io_no_rsp;
    data_rsp_out = memory_io_no_rsp;
    if (state == RESPOND) begin
      if (grant_id == REQ_INST) inst_rsp_out = '{valid: 1'b1, data: rsp_data};
      else                      data_rsp_out = '{valid: 1'b1, data: rsp_data};
    end
  end

  // Registered request path; the counter saturates because WAIT is left the
  // moment it reaches the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant_id     <= REQ_INST;
      last_grant   <= REQ_INST;
      wd_cnt       <= '0;
      rsp_data     <= 32'h0;
      mem_req      <= memory_io_no_req;
      timeout_err  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state   <= state_next;
      mem_req <= do_grant ? granted_req : memory_io_no_req;
      if (do_grant) begin
        grant_id   <= grant_next;
        last_grant <= grant_next;
      end
      if (state == ISSUE)     wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + CNT_W'(1);
      if (rsp_hit) rsp_data <= mem_rsp.data;
      if (wd_expire) begin
        rsp_data    <= TIMEOUT_DATA;
        timeout_err <= 1'b1;
      end
      if (inst_drop || data_drop || (mem_rsp.valid && state != WAIT))
        protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected memory requests
// and requester responses, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  memory_io_req32 inst_req_in, data_req_in, mem_req;
  memory_io_rsp32 inst_rsp_out, data_rsp_out, mem_rsp;
  logic           inst_busy, data_busy, timeout_err, protocol_err;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req_in  (inst_req_in),
    .inst_rsp_out (inst_rsp_out),
    .data_req_in  (data_req_in),
    .data_rsp_out (data_rsp_out),
    .mem_req      (mem_req),
    .mem_rsp      (mem_rsp),
    .inst_busy    (inst_busy),
    .data_busy    (data_busy),
    .timeout_err  (timeout_err),
    .protocol_err (protocol_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } exp_req_t;

  typedef struct {
    logic        is_data;
    logic [31:0] data;
  } exp_rsp_t;

  exp_req_t    exp_req_q[$];
  exp_rsp_t    exp_rsp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cycle_cnt = 0;
  int          req_seen_cycle = 0;
  int          rsp_seen_cycle = 0;
  int          mem_latency = 2;
  logic        mem_mute = 1'b0;
  logic        stray_tog = 1'b0;
  logic        stray_seen;
  int          rsp_timer;
  logic [31:0] rsp_pending;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input logic [31:0] actual);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got 0x%08h expected nothing", name, actual);
  endtask

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic memory_io_req32 mkReq(input logic [31:0] addr, input logic we,
                                           input logic [31:0] wdata);
    memory_io_req32 r;
    r.valid = 1'b1;
    r.we    = we;
    r.be    = we ? 4'hF : 4'h0;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

  task automatic expectReq(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    exp_req_t e;
    e = '{addr: addr, we: we, wdata: wdata};
    exp_req_q.push_back(e);
  endtask

  task automatic expectRsp(input logic is_data, input logic [31:0] data);
    exp_rsp_t e;
    e = '{is_data: is_data, data: data};
    exp_rsp_q.push_back(e);
  endtask

  task automatic applyStimulus(input memory_io_req32 ireq, input memory_io_req32 dreq);
    @(negedge clk);
    inst_req_in = ireq;
    data_req_in = dreq;
    @(negedge clk);
    inst_req_in = memory_io_no_req;
    data_req_in = memory_io_no_req;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((inst_busy || data_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) reportFail(name, n);
    @(negedge clk);
  endtask

  task automatic resetDut(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput({tag, "_mem_req_valid"}, mem_req.valid, 0);
    checkOutput({tag, "_inst_rsp_valid"}, inst_rsp_out.valid, 0);
    checkOutput({tag, "_data_rsp_valid"}, data_rsp_out.valid, 0);
    checkOutput({tag, "_inst_busy"}, inst_busy, 0);
    checkOutput({tag, "_data_busy"}, data_busy, 0);
    checkOutput({tag, "_timeout_err"}, timeout_err, 0);
    checkOutput({tag, "_protocol_err"}, protocol_err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Memory model: answers each request after mem_latency negedges unless muted,
  // and injects a stray response whenever stray_tog flips.
  initial begin
    mem_rsp    = memory_io_no_rsp;
    rsp_timer  = 0;
    stray_seen = 1'b0;
    rsp_pending = 32'h0;
    forever begin
      @(negedge clk);
      mem_rsp = memory_io_no_rsp;
      if (stray_tog != stray_seen) begin
        stray_seen = stray_tog;
        mem_rsp = '{valid: 1'b1, data: 32'h5757_5757};
      end else if (rsp_timer == 1) begin
        rsp_timer = 0;
        mem_rsp = '{valid: 1'b1, data: rsp_pending};
      end else if (rsp_timer > 1) begin
        rsp_timer--;
      end
      if (mem_req.valid && !mem_mute) begin
        rsp_timer   = mem_latency;
        rsp_pending = memData(mem_req.addr);
      end
    end
  end

  // Monitor: every presented mem_req and rsp_out pulse is matched to the scoreboard.
  initial begin
    exp_req_t e;
    exp_rsp_t r;
    forever begin
      @(negedge clk);
      if (reset && mem_req.valid) begin
        req_seen_cycle = cycle_cnt;
        if (exp_req_q.size() == 0) reportFail("mem_req_unexpected", mem_req.addr);
        else begin
          e = exp_req_q.pop_front();
          checkOutput("mem_req_addr", mem_req.addr, e.addr);
          checkOutput("mem_req_we", mem_req.we, e.we);
          checkOutput("mem_req_wdata", mem_req.wdata, e.wdata);
        end
      end
      if (inst_rsp_out.valid && data_rsp_out.valid) begin
        reportFail("rsp_both_valid", inst_rsp_out.data);
      end else if (inst_rsp_out.valid || data_rsp_out.valid) begin
        rsp_seen_cycle = cycle_cnt;
        if (exp_rsp_q.size() == 0)
          reportFail("rsp_unexpected", data_rsp_out.valid ? data_rsp_out.data : inst_rsp_out.data);
        else begin
          r = exp_rsp_q.pop_front();
          checkOutput("rsp_port_is_data", data_rsp_out.valid, r.is_data);
          checkOutput("rsp_data", data_rsp_out.valid ? data_rsp_out.data : inst_rsp_out.data, r.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    inst_req_in = memory_io_no_req;
    data_req_in = memory_io_no_req;
    reset = 1'b1;
    resetDut("init_reset");
    @(negedge clk);

    $display("[TB] single instruction read");
    mem_latency = 2;
    expectReq(32'h0000_0100, 1'b0, 32'h0);
    expectRsp(1'b0, 32'h0000_0093);
    applyStimulus(mkReq(32'h0000_0100, 1'b0, 32'h0), memory_io_no_req);
    waitIdle("t1_idle_timeout");
    checkOutput("t1_req_to_rsp_cycles", rsp_seen_cycle - req_seen_cycle, 3);
    checkOutput("t1_protocol_err", protocol_err, 0);

    $display("[TB] simultaneous requests after reset");
    resetDut("t2_reset");
    @(negedge clk);
    expectReq(32'h0000_2000, 1'b0, 32'h0);
    expectRsp(1'b1, 32'h2000_DFFF);
    expectReq(32'h0000_0100, 1'b0, 32'h0);
    expectRsp(1'b0, 32'h0000_0093);
    applyStimulus(mkReq(32'h0000_0100, 1'b0, 32'h0), mkReq(32'h0000_2000, 1'b0, 32'h0));
    waitIdle("t2_idle_timeout");

    $display("[TB] back-to-back request pairs");
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d_addr, i_addr, wd;
      logic        d_we;
      d_addr = 32'h0000_4000 + 32'(i * 16);
      i_addr = 32'h0000_1000 + 32'(i * 4);
      d_we   = (i % 2 == 1);
      wd     = d_we ? (32'hC0DE_0000 + 32'(i)) : 32'h0;
      expectReq(d_addr, d_we, wd);
      expectRsp(1'b1, memData(d_addr));
      expectReq(i_addr, 1'b0, 32'h0);
      expectRsp(1'b0, memData(i_addr));
      applyStimulus(mkReq(i_addr, 1'b0, 32'h0), mkReq(d_addr, d_we, wd));
      waitIdle("t3_idle_timeout");
    end
    checkOutput("t3_protocol_err", protocol_err, 0);

    $display("[TB] watchdog timeout on data read");
    mem_mute = 1'b1;
    expectReq(32'h0000_3000, 1'b0, 32'h0);
    expectRsp(1'b1, 32'hDEAD_BEEF);
    applyStimulus(memory_io_no_req, mkReq(32'h0000_3000, 1'b0, 32'h0));
    waitIdle("t4_idle_timeout");
    checkOutput("t4_req_to_rsp_cycles", rsp_seen_cycle - req_seen_cycle, 65);
    checkOutput("t4_timeout_err", timeout_err, 1);
    repeat (10) @(negedge clk);
    checkOutput("t4_timeout_err_sticky", timeout_err, 1);
    checkOutput("t4_protocol_err", protocol_err, 0);
    mem_mute = 1'b0;

    $display("[TB] dropped request and stray response");
    mem_latency = 6;
    expectReq(32'h0000_0400, 1'b0, 32'h0);
    expectRsp(1'b0, 32'h0400_FBFF);
    applyStimulus(mkReq(32'h0000_0400, 1'b0, 32'h0), memory_io_no_req);
    checkOutput("t5_inst_busy", inst_busy, 1);
    applyStimulus(mkReq(32'h0000_0404, 1'b0, 32'h0), memory_io_no_req);
    waitIdle("t5_idle_timeout");
    repeat (4) @(negedge clk);
    checkOutput("t5_drop_protocol_err", protocol_err, 1);
    resetDut("t5_reset");
    repeat (2) @(negedge clk);
    stray_tog = ~stray_tog;
    repeat (3) @(negedge clk);
    checkOutput("t5_stray_protocol_err", protocol_err, 1);
    checkOutput("t5_stray_inst_busy", inst_busy, 0);

    $display("[TB] reset during WAIT");
    resetDut("t6_pre_reset");
    @(negedge clk);
    mem_latency = 8;
    expectReq(32'h0000_0500, 1'b0, 32'h0);
    applyStimulus(mkReq(32'h0000_0500, 1'b0, 32'h0), memory_io_no_req);
    @(negedge clk);
    checkOutput("t6_in_wait_inst_busy", inst_busy, 1);
    resetDut("t6_wait_reset");
    repeat (8) @(negedge clk);
    checkOutput("t6_late_rsp_protocol_err", protocol_err, 1);
    checkOutput("t6_inst_busy", inst_busy, 0);
    checkOutput("t6_mem_req_valid", mem_req.valid, 0);

    repeat (2) @(negedge clk);
    checkOutput("req_queue_left", exp_req_q.size(), 0);
    checkOutput("rsp_queue_left", exp_rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified 32-bit memory port between the core's instruction-fetch and data requesters.
- Each requester port gets a one-entry capture slot, so a single-cycle request is never lost.
- Arbitrates round-robin and keeps exactly one memory transaction outstanding.
- Routes each memory response back to the requester that issued it, with a watchdog on missing responses.

Parameters:
- TIMEOUT_CYCLES, 64, WAIT-state cycles before an outstanding request is force-completed.
- TIMEOUT_DATA, 32'hDEAD_BEEF, data returned on a forced (timed-out) completion.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- inst_req_in  input  memory_io_req32  instruction requester request
- inst_rsp_out  output  memory_io_rsp32  instruction requester response
- data_req_in  input  memory_io_req32  data requester request
- data_rsp_out  output  memory_io_rsp32  data requester response
- mem_req  output  memory_io_req32  shared memory request
- mem_rsp  input  memory_io_rsp32  shared memory response
- inst_busy  output  1  instruction slot full or instruction transaction outstanding
- data_busy  output  1  data slot full or data transaction outstanding
- timeout_err  output  1  sticky; set on any watchdog expiry
- protocol_err  output  1  sticky; set on a dropped request or an unexpected response

Behaviour:
- Reset (reset==0, asynchronous):
  - all outputs return to memory_io_no_req / no-response values; busy and error flags 0
  - slots empty, FSM in IDLE, last_grant=INST (so data wins the first tie)
  - any in-flight transaction is abandoned; a late mem_rsp after reset release is counted as unexpected
- Capture:
  - at a posedge where req.valid==1 and that port's slot is empty, the whole request struct is latched
  - if the slot is full, or the port's transaction is outstanding, the request is dropped and protocol_err is set
- FSM states IDLE, ISSUE, WAIT, RESPOND:
  - IDLE: if any slot is full, grant one and go to ISSUE
    - if both are full, grant the port != last_grant, then update last_grant
    - the granted slot empties at grant; busy stays high via the outstanding flag
  - ISSUE: mem_req = granted request with valid=1 for exactly one cycle, then WAIT; mem_req is registered
  - WAIT: mem_req=no_req; watchdog counter increments each cycle
    - on mem_rsp.valid, latch rsp.data and go to RESPOND
    - if the counter reaches TIMEOUT_CYCLES, latch TIMEOUT_DATA, set timeout_err, go to RESPOND
  - RESPOND: the granted port's rsp_out has valid=1 for exactly one cycle; the other port's rsp_out stays invalid; outstanding clears; go to IDLE
- Every request, read or write, expects exactly one mem_rsp.
- mem_rsp.valid in any state other than WAIT is ignored and sets protocol_err.
- Latency, no contention: request valid at edge N is captured at N.
  - grant at N+1, mem_req.valid during cycle N+1..N+2 (ISSUE)
  - with a memory response during WAIT at edge M, rsp_out.valid is visible during cycle M..M+1
- A new capture on a port may coincide with that port's RESPOND cycle only if the slot is empty; busy deasserts the cycle after RESPOND.
- Watchdog counter: width $clog2(TIMEOUT_CYCLES+1); cleared on entry to WAIT; no wrap.
- Sticky error flags clear only on reset.

Decomposition:
- Shared package (with the memory_io types):
  - arbiter state enum {IDLE, ISSUE, WAIT, RESPOND}
  - requester-id enum {REQ_INST, REQ_DATA}
  - default TIMEOUT_DATA constant
- One natural sub-module, req_capture_slot:
  - one-entry request holding register with full flag, capture and release, and drop detection
  - instantiated twice

Test Plan:
- Reset then single instruction read addr 0x0000_0100; memory answers 2 cycles after mem_req with data 0x0000_0093 -> mem_req.addr=0x100 for 1 cycle; inst_rsp_out.valid one cycle with data 0x93; data_rsp_out never valid.
- Both ports request in the same cycle (inst 0x100, data 0x2000) after reset -> data granted first (mem_req.addr=0x2000), inst next; each response returned only on its own port, in that order.
- Four back-to-back request pairs, each issued as soon as busy deasserts -> grants alternate DATA, INST, DATA, INST...; no protocol_err.
- Memory never responds to data read 0x3000 -> after 64 WAIT cycles data_rsp_out.valid=1 with data 0xDEADBEEF; timeout_err=1 and stays 1.
- Second inst request while inst_busy=1; separately a stray mem_rsp.valid in IDLE -> the request is dropped, no extra mem_req is issued, protocol_err=1.
- reset driven low during WAIT, memory response arrives after release -> all outputs idle; stray response sets protocol_err; no rsp_out pulse.
